// File: rtl/fractal_pkg.sv
// fractal_pkg: shared frame geometry defaults, mode encoding and
// iteration limits for the fractal rendering pipeline.
package fractal_pkg;

  localparam int X_SIZE_DEF = 640;
  localparam int Y_SIZE_DEF = 480;
  localparam int ITER_W_DEF = 8;
  localparam int MAX_ITER   = (1 << ITER_W_DEF) - 1;

  typedef enum logic {
    MODE_MANDEL = 1'b0,
    MODE_JULIA  = 1'b1
  } mode_e;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y position in raster order with line and frame wrap,
// plus combinational last-column / last-row flags.
module raster_counter
  import fractal_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        x_last,
  output logic        y_last
);

  assign x_last = (x == 16'(X_SIZE - 1));
  assign y_last = (y == 16'(Y_SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 16'd1;
      end else begin
        x <= x + 16'd1;
      end
    end
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: hands raster pixels round-robin to N_ENG iteration
// engines and re-serialises their results in raster order.
module pixel_dispatcher
  import fractal_pkg::*;
#(
  parameter int N_ENG  = 4,
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF,
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    enable,
  input  logic                    cfg_mode,
  input  logic [N_ENG-1:0]        eng_idle,
  output logic [N_ENG-1:0]        eng_start,
  output logic [15:0]             eng_x,
  output logic [15:0]             eng_y,
  output logic                    eng_mode,
  input  logic [N_ENG-1:0]        eng_done,
  input  logic [N_ENG*ITER_W-1:0] eng_iter,
  output logic [N_ENG-1:0]        eng_ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ITER_W-1:0]       out_iter,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    frame_done
);

  localparam int PW = $clog2(N_ENG);

  logic [PW-1:0] ip;
  logic [PW-1:0] op;
  logic          issue;
  logic          load;
  logic          accept;
  logic          at_origin;
  logic          out_last;
  mode_e         mode_q;
  logic          ix_last;
  logic          iy_last;
  logic [15:0]   ox;
  logic [15:0]   oy;
  logic          ox_last;
  logic          oy_last;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] p);
    return (p == PW'(N_ENG - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshakes are gated by reset so every output reads 0 while held.
  assign issue  = enable & eng_idle[ip] & ~areset;
  assign load   = (~out_valid | out_ready) & eng_done[op] & ~areset;
  assign accept = out_valid & out_ready;

  always_comb begin
    eng_start     = '0;
    eng_ack       = '0;
    eng_start[ip] = issue;
    eng_ack[op]   = load;
  end

  // The engine starting (0,0) must already see the new frame's mode.
  assign eng_mode = (issue & at_origin) ? cfg_mode : mode_q;

  raster_counter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) u_issue_pos (
    .clk    (aclk),
    .rst    (areset),
    .adv    (issue),
    .x      (eng_x),
    .y      (eng_y),
    .x_last (ix_last),
    .y_last (iy_last)
  );

  raster_counter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) u_out_pos (
    .clk    (aclk),
    .rst    (areset),
    .adv    (load),
    .x      (ox),
    .y      (oy),
    .x_last (ox_last),
    .y_last (oy_last)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ip         <= '0;
      op         <= '0;
      at_origin  <= 1'b1;
      mode_q     <= MODE_MANDEL;
      out_valid  <= 1'b0;
      out_iter   <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & out_last;
      if (issue) begin
        ip        <= rr_next(ip);
        at_origin <= ix_last & iy_last;
        if (at_origin) mode_q <= mode_e'(cfg_mode);
      end
      // ox/oy name the pixel being loaded, so flags travel with the beat.
      if (load) begin
        op        <= rr_next(op);
        out_valid <= 1'b1;
        out_iter  <= eng_iter[int'(op)*ITER_W +: ITER_W];
        out_sof   <= (ox == '0) && (oy == '0);
        out_eol   <= ox_last;
        out_last  <= ox_last & oy_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb_pixel_dispatcher: randomized engines plus a raster-order scoreboard
// checking issue order, output stream, handshakes and frame pulses.
module tb_pixel_dispatcher;

  localparam int N  = 4;
  localparam int XS = 8;
  localparam int YS = 2;
  localparam int IW = 8;
  localparam int FR = XS * YS;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  eng_idle;
  logic [N-1:0]  eng_start;
  logic [N-1:0]  eng_done;
  logic [N-1:0]  eng_ack;
  logic [15:0]   eng_x;
  logic [15:0]   eng_y;
  logic          eng_mode;
  logic [N*IW-1:0] eng_iter;
  logic          out_valid;
  logic [IW-1:0] out_iter;
  logic          out_sof;
  logic          out_eol;
  logic          frame_done;

  always #5 aclk = ~aclk;

  pixel_dispatcher #(
    .N_ENG  (N),
    .X_SIZE (XS),
    .Y_SIZE (YS),
    .ITER_W (IW)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .enable     (enable),
    .cfg_mode   (cfg_mode),
    .eng_idle   (eng_idle),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_mode   (eng_mode),
    .eng_done   (eng_done),
    .eng_iter   (eng_iter),
    .eng_ack    (eng_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_iter   (out_iter),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .frame_done (frame_done)
  );

  function automatic logic [IW-1:0] ref_iter(int x, int y, bit m);
    return IW'((x * 37 + y * 11 + (m ? 101 : 0) + 5) % 256);
  endfunction

  // Engine models: fixed or random latency, hold result until acked.
  logic [N-1:0]  busy;
  int            cnt [N];
  int            lat [N];
  bit            rnd_lat;
  logic [IW-1:0] res [N];

  assign eng_idle = ~busy | (eng_done & eng_ack);

  always_comb begin
    eng_iter = '0;
    for (int i = 0; i < N; i++)
      eng_iter[i*IW +: IW] = eng_done[i] ? res[i] : '0;
  end

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      busy     <= '0;
      eng_done <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (eng_start[i]) begin
          busy[i]     <= 1'b1;
          eng_done[i] <= 1'b0;
          cnt[i]      <= rnd_lat ? int'($urandom_range(0, 5)) : lat[i];
          res[i]      <= ref_iter(int'(eng_x), int'(eng_y), eng_mode);
        end else if (eng_done[i] && eng_ack[i]) begin
          busy[i]     <= 1'b0;
          eng_done[i] <= 1'b0;
        end else if (busy[i] && !eng_done[i]) begin
          if (cnt[i] == 0) eng_done[i] <= 1'b1;
          else cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  // Scoreboard: pixel k goes to engine k mod N and leaves as beat k.
  int n_cmp = 0;
  int n_bad = 0;
  int icnt, lcnt, m_idx, acc_cnt;
  bit m_valid, fd_pend;
  bit fm [64];

  task automatic model_reset();
    icnt = 0;
    lcnt = 0;
    m_idx = 0;
    acc_cnt = 0;
    m_valid = 0;
    fd_pend = 0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    enable = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    model_reset();
  endtask

  task automatic tick();
    int e, ex, ey;
    bit ld;
    logic [N-1:0] exp_s, exp_a;
    #1;
    e = icnt % N;
    exp_s = '0;
    if (enable && eng_idle[e]) exp_s[e] = 1'b1;
    n_cmp++;
    if (eng_start !== exp_s) begin
      n_bad++;
      $display("FAIL issue k=%0d: eng_start=%b want %b", icnt, eng_start, exp_s);
    end
    if (exp_s != '0) begin
      if (icnt % FR == 0) fm[(icnt / FR) % 64] = cfg_mode;
      n_cmp++;
      if (eng_x !== 16'(icnt % XS) || eng_y !== 16'((icnt / XS) % YS) ||
          eng_mode !== fm[(icnt / FR) % 64]) begin
        n_bad++;
        $display("FAIL issue_pos k=%0d: x=%0d y=%0d m=%b want %0d %0d %b",
                 icnt, eng_x, eng_y, eng_mode, icnt % XS, (icnt / XS) % YS,
                 fm[(icnt / FR) % 64]);
      end
      icnt++;
    end
    e = lcnt % N;
    ld = (!m_valid || out_ready) && eng_done[e];
    exp_a = '0;
    if (ld) exp_a[e] = 1'b1;
    n_cmp++;
    if (eng_ack !== exp_a) begin
      n_bad++;
      $display("FAIL ack beat=%0d: eng_ack=%b want %b", lcnt, eng_ack, exp_a);
    end
    n_cmp++;
    if (out_valid !== m_valid) begin
      n_bad++;
      $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
    end
    if (m_valid) begin
      ex = m_idx % XS;
      ey = (m_idx / XS) % YS;
      n_cmp++;
      if (out_iter !== ref_iter(ex, ey, fm[(m_idx / FR) % 64]) ||
          out_sof !== (m_idx % FR == 0) || out_eol !== (ex == XS - 1)) begin
        n_bad++;
        $display("FAIL beat %0d: iter=%0d sof=%b eol=%b want %0d %b %b",
                 m_idx, out_iter, out_sof, out_eol,
                 ref_iter(ex, ey, fm[(m_idx / FR) % 64]),
                 m_idx % FR == 0, ex == XS - 1);
      end
    end
    n_cmp++;
    if (frame_done !== fd_pend) begin
      n_bad++;
      $display("FAIL frame_done: got %b want %b", frame_done, fd_pend);
    end
    fd_pend = m_valid && out_ready && (m_idx % FR == FR - 1);
    if (m_valid && out_ready) acc_cnt++;
    if (ld) begin
      m_valid = 1'b1;
      m_idx = lcnt;
      lcnt++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    cfg_mode = 1'b1;
    @(negedge aclk);
    #1;
    n_cmp++;
    if ({eng_start, eng_x, eng_y, eng_mode, eng_ack} !== '0) begin
      n_bad++;
      $display("FAIL reset_issue: start=%b x=%0d y=%0d m=%b ack=%b",
               eng_start, eng_x, eng_y, eng_mode, eng_ack);
    end
    n_cmp++;
    if ({out_valid, out_iter, out_sof, out_eol, frame_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: v=%b iter=%0d sof=%b eol=%b fd=%b",
               out_valid, out_iter, out_sof, out_eol, frame_done);
    end
    cfg_mode = 1'b0;
    do_reset();
  endtask

  task automatic test_first_issue();
    int budget;
    do_reset();
    rnd_lat = 0;
    for (int i = 0; i < N; i++) lat[i] = 0;
    enable = 1'b1;
    for (int c = 0; c < N; c++) begin
      #1;
      n_cmp++;
      if (eng_start !== N'(1 << c) || eng_x !== 16'(c) || eng_y !== 16'd0) begin
        n_bad++;
        $display("FAIL first_issue c=%0d: start=%b x=%0d y=%0d",
                 c, eng_start, eng_x, eng_y);
      end
      tick();
    end
    budget = 0;
    while (!m_valid && budget < 10) begin
      tick();
      budget++;
    end
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_iter !== ref_iter(0, 0, 0)) begin
      n_bad++;
      $display("FAIL first_beat: v=%b sof=%b iter=%0d want 1 1 %0d",
               out_valid, out_sof, out_iter, ref_iter(0, 0, 0));
    end
    out_ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_out_of_order();
    bit seen;
    do_reset();
    rnd_lat = 0;
    lat[0] = 6;
    lat[1] = 6;
    lat[2] = 0;
    lat[3] = 6;
    enable = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (30) begin
      #1;
      if (eng_done[2] && lcnt < 2) seen = 1;
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL ooo_holdoff: engine 2 never waited, got %b want 1", seen);
    end
  endtask

  task automatic test_backpressure();
    int budget, acc;
    logic [IW-1:0] held;
    do_reset();
    rnd_lat = 0;
    for (int i = 0; i < N; i++) lat[i] = 0;
    enable = 1'b1;
    budget = 0;
    while (!m_valid && budget < 10) begin
      tick();
      budget++;
    end
    #1;
    held = out_iter;
    repeat (5) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_iter !== held || eng_ack !== '0) begin
        n_bad++;
        $display("FAIL stall: v=%b iter=%0d ack=%b want 1 %0d 0",
                 out_valid, out_iter, eng_ack, held);
      end
      tick();
    end
    out_ready = 1'b1;
    acc = 0;
    repeat (4) begin
      #1;
      if (out_valid) acc++;
      tick();
    end
    n_cmp++;
    if (acc != 4) begin
      n_bad++;
      $display("FAIL resume_rate: %0d beats in 4 cycles, want 4", acc);
    end
    repeat (8) tick();
  endtask

  task automatic test_full_frame();
    int budget, fd_obs;
    do_reset();
    rnd_lat = 1;
    cfg_mode = 1'b0;
    enable = 1'b1;
    budget = 0;
    fd_obs = 0;
    while (acc_cnt < FR + 2 && budget < 1000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (frame_done) fd_obs++;
      tick();
      budget++;
    end
    if (budget >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: %0d beats accepted, want %0d", acc_cnt, FR + 2);
    end
    out_ready = 1'b0;
    #1;
    if (frame_done) fd_obs++;
    tick();
    n_cmp++;
    if (fd_obs != 1) begin
      n_bad++;
      $display("FAIL frame_done_count: got %0d want 1", fd_obs);
    end
  endtask

  task automatic test_mode_switch();
    int budget;
    do_reset();
    rnd_lat = 1;
    cfg_mode = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    budget = 0;
    while (acc_cnt < FR + 4 && budget < 1000) begin
      cfg_mode = (icnt >= 5);
      #1;
      if (eng_start != '0) begin
        n_cmp++;
        if (eng_mode !== (icnt >= FR)) begin
          n_bad++;
          $display("FAIL mode_latch k=%0d: eng_mode=%b want %b",
                   icnt, eng_mode, icnt >= FR);
        end
      end
      tick();
      budget++;
    end
    if (budget >= 1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mode_timeout: %0d beats accepted", acc_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    int budget;
    do_reset();
    rnd_lat = 0;
    for (int i = 0; i < N; i++) lat[i] = 8;
    enable = 1'b1;
    out_ready = 1'b1;
    budget = 0;
    while (icnt < 3 && budget < 20) begin
      tick();
      budget++;
    end
    enable = 1'b0;
    tick();
    #3;
    areset = 1'b1;
    #1;
    n_cmp++;
    if ({eng_start, eng_x, eng_y, eng_ack, eng_done} !== '0 ||
        {out_valid, out_iter, out_sof, out_eol, frame_done} !== '0) begin
      n_bad++;
      $display("FAIL midreset: start=%b x=%0d y=%0d ack=%b v=%b iter=%0d",
               eng_start, eng_x, eng_y, eng_ack, out_valid, out_iter);
    end
    @(negedge aclk);
    areset = 1'b0;
    model_reset();
    enable = 1'b1;
    #1;
    n_cmp++;
    if (eng_start !== 4'b0001 || eng_x !== 16'd0 || eng_y !== 16'd0) begin
      n_bad++;
      $display("FAIL restart: start=%b x=%0d y=%0d want 0001 0 0",
               eng_start, eng_x, eng_y);
    end
    repeat (30) tick();
  endtask

  task automatic test_random();
    do_reset();
    rnd_lat = 1;
    repeat (800) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) cfg_mode = ~cfg_mode;
      tick();
    end
  endtask

  initial begin
    rnd_lat = 0;
    for (int i = 0; i < N; i++) lat[i] = 0;
    model_reset();
    @(negedge aclk);
    test_reset();
    test_first_issue();
    test_out_of_order();
    test_backpressure();
    test_full_frame();
    test_mode_switch();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
